player_action_scheduler: RTL and testbench

Frame-rate sequencer that sits between the controller input decoder and the player/sword datapath. It samples buttons only on frame ticks and issues single-cycle move and attack commands with a direction. It enforces move cooldown, attack duration and attack recovery timing. It also latches the dead condition so the datapath freezes once health reaches zero.

---
 rtl/player_action_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_player_action_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/player_action_scheduler.sv
// Frame-rate action sequencer: samples buttons on frame ticks and issues move/attack
// commands while enforcing move cooldown, sword duration, recovery and a sticky dead state.
module player_action_scheduler #(
    parameter int unsigned MOVE_COOLDOWN   = 8,
    parameter int unsigned ATTACK_FRAMES   = 4,
    parameter int unsigned ATTACK_COOLDOWN = 12,
    parameter int unsigned CNT_W           = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       A,
    input  logic       B,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic [1:0] player_health,
    output logic       move_en,
    output logic       attack_start,
    output logic       sword_active,
    output logic [1:0] cmd_dir,
    output logic [1:0] facing,
    output logic       busy,
    output logic       game_over,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MOVE_WAIT = 3'd1,
        ATTACK    = 3'd2,
        RECOVER   = 3'd3,
        DEAD      = 3'd4
    } state_e;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam logic [CNT_W-1:0] MOVE_RELOAD = CNT_W'(MOVE_COOLDOWN - 1);
    localparam logic [CNT_W-1:0] ATK_RELOAD  = CNT_W'(ATTACK_FRAMES - 1);
    localparam logic [CNT_W-1:0] REC_RELOAD  = CNT_W'(ATTACK_COOLDOWN - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       facing_q, facing_d;
    logic [1:0]       cmd_q, cmd_d;
    logic             move_q, move_d;
    logic             atk_start_q, atk_start_d;
    logic             sword_q, sword_d;
    logic             over_q, over_d;
    logic             busy_q;
    logic             atk_prev_q, atk_prev_d;

    logic       dir_valid_c;
    logic [1:0] dir_c;
    logic       atk_any_c;
    logic       atk_req_c;

    // Direction decode: only a single held direction counts as valid.
    always_comb begin
        dir_valid_c = ($countones({up, right, down, left}) == 1);
        dir_c       = DIR_UP;
        if (right) begin
            dir_c = DIR_RIGHT;
        end else if (down) begin
            dir_c = DIR_DOWN;
        end else if (left) begin
            dir_c = DIR_LEFT;
        end
        atk_any_c = A | B;
        atk_req_c = atk_any_c & ~atk_prev_q;
    end

    // Next-state and next-output logic; pulses default low so they last one cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        facing_d    = facing_q;
        cmd_d       = cmd_q;
        sword_d     = sword_q;
        over_d      = over_q;
        atk_prev_d  = atk_prev_q;
        move_d      = 1'b0;
        atk_start_d = 1'b0;

        if (frame_tick) begin
            atk_prev_d = atk_any_c;
            if (player_health == 2'd0) begin
                state_d = DEAD;
                sword_d = 1'b0;
                over_d  = 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (atk_req_c) begin
                            cmd_d       = dir_valid_c ? dir_c : facing_q;
                            facing_d    = dir_valid_c ? dir_c : facing_q;
                            atk_start_d = 1'b1;
                            sword_d     = 1'b1;
                            cnt_d       = ATK_RELOAD;
                            state_d     = ATTACK;
                        end else if (dir_valid_c) begin
                            cmd_d    = dir_c;
                            facing_d = dir_c;
                            move_d   = 1'b1;
                            cnt_d    = MOVE_RELOAD;
                            state_d  = MOVE_WAIT;
                        end
                    end
                    MOVE_WAIT: begin
                        if (cnt_q == CNT_ZERO) begin
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                    ATTACK: begin
                        if (cnt_q == CNT_ZERO) begin
                            sword_d = 1'b0;
                            cnt_d   = REC_RELOAD;
                            state_d = RECOVER;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                    RECOVER: begin
                        if (cnt_q == CNT_ZERO) begin
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                    DEAD: begin
                        state_d = DEAD;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_ZERO;
            facing_q    <= DIR_RIGHT;
            cmd_q       <= DIR_RIGHT;
            move_q      <= 1'b0;
            atk_start_q <= 1'b0;
            sword_q     <= 1'b0;
            over_q      <= 1'b0;
            busy_q      <= 1'b0;
            atk_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            facing_q    <= facing_d;
            cmd_q       <= cmd_d;
            move_q      <= move_d;
            atk_start_q <= atk_start_d;
            sword_q     <= sword_d;
            over_q      <= over_d;
            busy_q      <= (state_d != IDLE);
            atk_prev_q  <= atk_prev_d;
        end
    end

    assign move_en      = move_q;
    assign attack_start = atk_start_q;
    assign sword_active = sword_q;
    assign cmd_dir      = cmd_q;
    assign facing       = facing_q;
    assign busy         = busy_q;
    assign game_over    = over_q;
    assign state        = state_q;

endmodule

// File: tb/tb_player_action_scheduler.sv
// Scoreboard bench for player_action_scheduler: a tick-timestamp reference model predicts
// every cycle's outputs; a monitor compares them one cycle after each driven edge.
module tb_player_action_scheduler;

    localparam int MOVE_CD = 8;
    localparam int ATK_FR  = 4;
    localparam int ATK_CD  = 12;

    localparam logic [3:0] D_NONE  = 4'b0000;
    localparam logic [3:0] D_UP    = 4'b0001;
    localparam logic [3:0] D_RIGHT = 4'b0010;
    localparam logic [3:0] D_DOWN  = 4'b0100;
    localparam logic [3:0] D_LEFT  = 4'b1000;

    typedef struct packed {
        logic       mv;
        logic       as;
        logic       sw;
        logic [1:0] cmd;
        logic [1:0] fac;
        logic       busy;
        logic       go;
        logic [2:0] st;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset, frame_tick, A, B, up, down, left, right;
    logic [1:0] player_health;
    logic       move_en, attack_start, sword_active, busy, game_over;
    logic [1:0] cmd_dir, facing;
    logic [2:0] state;

    player_action_scheduler dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .A(A), .B(B),
        .up(up), .down(down), .left(left), .right(right),
        .player_health(player_health), .move_en(move_en), .attack_start(attack_start),
        .sword_active(sword_active), .cmd_dir(cmd_dir), .facing(facing), .busy(busy),
        .game_over(game_over), .state(state)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   started = 1'b0;

    // Reference model: modes 0 idle, 1 move wait, 2 attack, 3 recover, 4 dead.
    // Phase boundaries are expressed as tick timestamps relative to the accepting tick.
    int   m_mode, m_tick, m_start;
    logic [1:0] m_facing, m_cmd;
    logic m_sword, m_over, m_prev;

    task automatic model_step(input logic rst, input logic tk, input logic a, input logic b,
                              input logic [3:0] d, input logic [1:0] hp, output obs_t e);
        logic mv, as, req, dv;
        logic [1:0] dir;
        mv = 1'b0;
        as = 1'b0;
        if (rst) begin
            m_mode = 0; m_tick = 0; m_start = 0;
            m_facing = 2'd1; m_cmd = 2'd1;
            m_sword = 1'b0; m_over = 1'b0; m_prev = 1'b0;
        end else if (tk) begin
            m_tick++;
            dv  = ($countones(d) == 1);
            dir = 2'd0;
            for (int i = 0; i < 4; i++) if (d[i]) dir = 2'(i);
            req    = (a | b) & ~m_prev;
            m_prev = a | b;
            if (hp == 2'd0) begin
                m_mode = 4; m_sword = 1'b0; m_over = 1'b1;
            end else begin
                case (m_mode)
                    0: begin
                        if (req) begin
                            m_cmd = dv ? dir : m_facing;
                            m_facing = m_cmd;
                            as = 1'b1; m_sword = 1'b1; m_mode = 2; m_start = m_tick;
                        end else if (dv) begin
                            m_cmd = dir; m_facing = dir;
                            mv = 1'b1; m_mode = 1; m_start = m_tick;
                        end
                    end
                    1: if (m_tick - m_start == MOVE_CD) m_mode = 0;
                    2: if (m_tick - m_start == ATK_FR) begin m_sword = 1'b0; m_mode = 3; end
                    3: if (m_tick - m_start == ATK_FR + ATK_CD) m_mode = 0;
                    default: ;
                endcase
            end
        end
        e = '{mv: mv, as: as, sw: m_sword, cmd: m_cmd, fac: m_facing,
              busy: (m_mode != 0), go: m_over, st: 3'(m_mode)};
    endtask

    // Drive one cycle of inputs on the falling edge and queue the predicted response.
    task automatic cyc(input logic rst, input logic tk, input logic a, input logic b,
                       input logic [3:0] d, input logic [1:0] hp);
        obs_t e;
        @(negedge clk);
        reset = rst; frame_tick = tk; A = a; B = b;
        up = d[0]; right = d[1]; down = d[2]; left = d[3];
        player_health = hp;
        model_step(rst, tk, a, b, d, hp, e);
        exp_q.push_back(e);
        started = 1'b1;
    endtask

    task automatic tick_n(input int n, input logic a, input logic b,
                          input logic [3:0] d, input logic [1:0] hp);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, a, b, d, hp);
            cyc(1'b0, 1'b0, a, b, d, hp);
        end
    endtask

    // Monitor: one expected record per clock edge once stimulus has begun.
    initial begin
        obs_t e, got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                if (started) begin
                    n_tests++; n_fail++;
                    $display("FAIL scoreboard_underflow at %0t", $time);
                end
            end else begin
                e   = exp_q.pop_front();
                got = obs_t'({move_en, attack_start, sword_active, cmd_dir, facing,
                              busy, game_over, state});
                n_tests++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t got mv=%b as=%b sw=%b cmd=%b fac=%b busy=%b go=%b st=%0d, expected mv=%b as=%b sw=%b cmd=%b fac=%b busy=%b go=%b st=%0d",
                             $time, got.mv, got.as, got.sw, got.cmd, got.fac, got.busy, got.go, got.st,
                             e.mv, e.as, e.sw, e.cmd, e.fac, e.busy, e.go, e.st);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a, b, tk_prev, rst, tk;
        logic [3:0] d;
        logic [1:0] hp;
        reset = 1'b1; frame_tick = 1'b0; A = 1'b0; B = 1'b0;
        up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0; player_health = 2'd3;

        cyc(1'b1, 1'b0, 1'b0, 1'b0, D_NONE, 2'd3);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, D_UP, 2'd3);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, D_NONE, 2'd3);

        // Move with right held through cooldown and into a second move.
        tick_n(1, 1'b0, 1'b0, D_RIGHT, 2'd3);
        tick_n(9, 1'b0, 1'b0, D_RIGHT, 2'd3);
        tick_n(9, 1'b0, 1'b0, D_NONE, 2'd3);
        // Two directions at once is no direction.
        tick_n(2, 1'b0, 1'b0, D_UP | D_LEFT, 2'd3);
        // Attack facing down, full duration and recovery.
        tick_n(1, 1'b1, 1'b0, D_DOWN, 2'd3);
        tick_n(18, 1'b0, 1'b0, D_NONE, 2'd3);
        // Held button fires once; release then re-press.
        tick_n(30, 1'b1, 1'b0, D_NONE, 2'd3);
        tick_n(1, 1'b0, 1'b0, D_NONE, 2'd3);
        tick_n(20, 1'b1, 1'b0, D_NONE, 2'd3);
        tick_n(1, 1'b0, 1'b0, D_NONE, 2'd3);
        // Attack wins over move; later B with no direction uses facing.
        tick_n(1, 1'b1, 1'b0, D_RIGHT, 2'd3);
        tick_n(17, 1'b0, 1'b0, D_NONE, 2'd3);
        tick_n(3, 1'b0, 1'b1, D_NONE, 2'd3);
        tick_n(1, 1'b0, 1'b0, D_NONE, 2'd3);
        // Death mid-attack, inputs ignored afterwards, then reset.
        tick_n(16, 1'b0, 1'b0, D_NONE, 2'd3);
        tick_n(1, 1'b1, 1'b0, D_LEFT, 2'd2);
        tick_n(1, 1'b0, 1'b0, D_NONE, 2'd2);
        tick_n(1, 1'b0, 1'b0, D_NONE, 2'd0);
        tick_n(3, 1'b1, 1'b0, D_UP, 2'd3);
        tick_n(2, 1'b0, 1'b0, D_DOWN, 2'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, D_NONE, 2'd3);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, D_NONE, 2'd3);

        // Randomized phase: single-cycle ticks, sticky buttons, rare death and reset.
        a = 1'b0; b = 1'b0; d = D_NONE; tk_prev = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = ($urandom_range(0, 2) == 0);
                b = ($urandom_range(0, 4) == 0);
                case ($urandom_range(0, 9))
                    0, 1:    d = D_NONE;
                    2, 3, 4: d = 4'(4'b0001 << $urandom_range(0, 3));
                    5, 6:    d = 4'(1 << $urandom_range(0, 3));
                    default: d = 4'($urandom_range(0, 15));
                endcase
            end
            rst = ($urandom_range(0, 399) == 0);
            tk  = !tk_prev && ($urandom_range(0, 1) == 0);
            hp  = ($urandom_range(0, 299) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            cyc(rst, tk, a, b, d, hp);
            tk_prev = tk;
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, D_NONE, 2'd3);

        @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
